// File: rtl/tracker_pkg.sv
// Shared types and widths for the per-object motion tracker.
package tracker_pkg;

  localparam int X_W  = 11;
  localparam int Y_W  = 10;
  localparam int XV_W = X_W + 1;
  localparam int YV_W = Y_W + 1;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2,
    COAST   = 2'd3
  } state_t;

  // Per-frame action applied identically to both axes.
  typedef enum logic [2:0] {
    CMD_HOLD      = 3'd0,  // keep position and velocity
    CMD_LOAD_ZERO = 3'd1,  // load the centroid, velocity 0
    CMD_LOAD_VEL  = 3'd2,  // velocity = new - old, load the centroid
    CMD_PREDICT   = 3'd3,  // position += velocity (clamped), keep velocity
    CMD_CLEAR_VEL = 3'd4   // keep position, velocity 0
  } axis_cmd_t;

endpackage

// File: rtl/object_tracker_if.sv
// Centroid-in / track-out bundle between the centroid stage and the tracker.
interface object_tracker_if;
  import tracker_pkg::*;

  logic                   frame_done;
  logic [X_W-1:0]         x_center;
  logic [Y_W-1:0]         y_center;
  logic [X_W-1:0]         x_track;
  logic [Y_W-1:0]         y_track;
  logic signed [XV_W-1:0] x_vel;
  logic signed [YV_W-1:0] y_vel;
  logic                   track_valid;
  logic [1:0]             state;
  logic                   update;

  modport master (
    output frame_done, x_center, y_center,
    input  x_track, y_track, x_vel, y_vel, track_valid, state, update
  );

  modport slave (
    input  frame_done, x_center, y_center,
    output x_track, y_track, x_vel, y_vel, track_valid, state, update
  );

endinterface

// File: rtl/axis_tracker.sv
// One axis of the tracker: holds position and velocity, evaluates the
// jump test against the current (possibly predicted) position, and applies
// the per-frame command chosen by the FSM.
module axis_tracker
  import tracker_pkg::*;
#(
  parameter int W        = 11,
  parameter int MAX_JUMP = 200
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  axis_cmd_t           cmd,
  input  logic [W-1:0]        center,
  output logic                jump,
  output logic [W-1:0]        pos,
  output logic signed [W:0]   vel
);

  localparam logic [W:0] JUMP_LIM = W'(MAX_JUMP) + (W+1)'(0);

  logic signed [W:0]   diff;
  logic [W:0]          adiff;
  logic signed [W+1:0] sum;

  // Prediction saturates at the frame edges instead of wrapping.
  function automatic logic [W-1:0] sat_pos(input logic signed [W+1:0] s);
    if (s < 0)
      return '0;
    else if (s > $signed({2'b00, {W{1'b1}}}))
      return '1;
    else
      return s[W-1:0];
  endfunction

  // Difference is one bit wider than the operands so it never overflows;
  // it doubles as the new velocity.
  always_comb begin
    diff  = $signed({1'b0, center}) - $signed({1'b0, pos});
    adiff = (diff < 0) ? W'(0) - diff : diff;
    jump  = (adiff > JUMP_LIM);
    sum   = $signed({2'b00, pos}) + $signed({vel[W], vel});
  end

  // Position/velocity update on each frame strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos <= '0;
      vel <= '0;
    end else if (en) begin
      unique case (cmd)
        CMD_LOAD_ZERO: begin
          pos <= center;
          vel <= '0;
        end
        CMD_LOAD_VEL: begin
          pos <= center;
          vel <= diff;
        end
        CMD_PREDICT:   pos <= sat_pos(sum);
        CMD_CLEAR_VEL: vel <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/object_tracker.sv
// Per-object acquire/track/coast tracker. Once per frame_done strobe the
// FSM classifies the centroid (none / good / jump) and issues one command
// to both axis datapaths; outputs are valid from the strobe edge onward.
module object_tracker
  import tracker_pkg::*;
#(
  parameter int ACQUIRE_FRAMES = 3,
  parameter int MISS_LIMIT     = 8,
  parameter int MAX_JUMP       = 200
) (
  input  logic             clk,
  input  logic             reset,
  object_tracker_if.slave  bus
);

  localparam logic [3:0] ACQ_N  = 4'(ACQUIRE_FRAMES);
  localparam logic [3:0] MISS_N = 4'(MISS_LIMIT);

  state_t     state_q, state_n;
  logic [3:0] hit_q, hit_n;
  logic [3:0] miss_q, miss_n;
  logic       valid_q;
  logic       update_p1;
  axis_cmd_t  cmd;
  logic       x_jump, y_jump;
  logic       det, good;

  axis_tracker #(.W(X_W), .MAX_JUMP(MAX_JUMP)) u_x (
    .clk    (clk),
    .reset  (reset),
    .en     (bus.frame_done),
    .cmd    (cmd),
    .center (bus.x_center),
    .jump   (x_jump),
    .pos    (bus.x_track),
    .vel    (bus.x_vel)
  );

  axis_tracker #(.W(Y_W), .MAX_JUMP(MAX_JUMP)) u_y (
    .clk    (clk),
    .reset  (reset),
    .en     (bus.frame_done),
    .cmd    (cmd),
    .center (bus.y_center),
    .jump   (y_jump),
    .pos    (bus.y_track),
    .vel    (bus.y_vel)
  );

  // Upstream forces (0,0) when too few pixels matched: that means "no object".
  always_comb begin
    det  = (bus.x_center != '0) || (bus.y_center != '0);
    good = det && !(x_jump || y_jump);
  end

  // Next-state, counters and axis command; everything holds without a strobe.
  always_comb begin
    state_n = state_q;
    hit_n   = hit_q;
    miss_n  = miss_q;
    cmd     = CMD_HOLD;
    if (bus.frame_done) begin
      unique case (state_q)
        SEARCH: begin
          if (det) begin
            cmd     = CMD_LOAD_ZERO;
            hit_n   = 4'd1;
            state_n = ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (good) begin
            cmd   = CMD_LOAD_VEL;
            hit_n = hit_q + 4'd1;
            if (hit_q + 4'd1 == ACQ_N)
              state_n = TRACK;
          end else if (det) begin
            cmd   = CMD_LOAD_ZERO;
            hit_n = 4'd1;
          end else begin
            cmd     = CMD_CLEAR_VEL;
            hit_n   = 4'd0;
            state_n = SEARCH;
          end
        end
        TRACK: begin
          if (good) begin
            cmd    = CMD_LOAD_VEL;
            miss_n = 4'd0;
          end else begin
            miss_n = 4'd1;
            if (MISS_N == 4'd1) begin
              // A single tolerated miss is already the limit: drop the track.
              cmd     = CMD_CLEAR_VEL;
              state_n = SEARCH;
            end else begin
              cmd     = CMD_PREDICT;
              state_n = COAST;
            end
          end
        end
        COAST: begin
          if (good) begin
            cmd     = CMD_LOAD_VEL;
            miss_n  = 4'd0;
            state_n = TRACK;
          end else begin
            miss_n = miss_q + 4'd1;
            if (miss_q + 4'd1 == MISS_N) begin
              cmd     = CMD_CLEAR_VEL;
              state_n = SEARCH;
            end else begin
              cmd = CMD_PREDICT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State, counters, registered valid flag and update pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SEARCH;
      hit_q     <= '0;
      miss_q    <= '0;
      valid_q   <= 1'b0;
      update_p1 <= 1'b0;
    end else begin
      state_q   <= state_n;
      hit_q     <= hit_n;
      miss_q    <= miss_n;
      valid_q   <= (state_n == TRACK) || (state_n == COAST);
      update_p1 <= bus.frame_done;
    end
  end

  assign bus.state       = state_q;
  assign bus.track_valid = valid_q;
  assign bus.update      = update_p1;

endmodule
